add_arb: RTL and testbench
==========================

ADD_ARB -- requirements
Module: add_arb

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 63, where operand and sum width W = DATAWIDTH+1 bits ([DATAWIDTH:0]).
REQ-002 The block SHALL serve exactly 4 requesters; the requester count is not a parameter.
REQ-003 Clk  input  1  rising-edge clock; the block has one clock.
REQ-004 Rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  4  per-requester request valid, bit i = requester i.
REQ-006 req_a  input  4*W  operand A; requester i occupies bits [i*W +: W].
REQ-007 req_b  input  4*W  operand B; same packing as req_a.
REQ-008 req_ready  output  4  one-hot grant/accept; combinational.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_sum  output  W  registered sum.
REQ-011 res_carry  output  1  registered carry-out of the sum.
REQ-012 res_id  output  2  index of the requester that produced the held result.
REQ-013 res_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 The block SHALL contain one W-bit adder shared by all requesters, plus a one-entry output register.
REQ-015 can_accept SHALL be defined as (!res_valid || res_ready).
REQ-016 When can_accept=1 and any req_valid bit is set, the block SHALL grant the first set index found by scanning upward from rr_ptr, modulo 4.
REQ-017 req_ready SHALL be all-zero when can_accept=0, when no req_valid bit is set, or while Rst=1.
REQ-018 Grant logic SHALL be combinational; req_ready[g] SHALL be asserted in the same cycle as the qualifying req_valid.
REQ-019 A transfer on requester g occurs at a rising edge with req_valid[g]=1 and req_ready[g]=1.
REQ-020 On each transfer, the block SHALL update state as follows:
- {res_carry,res_sum} <= req_a[g] + req_b[g], computed at W+1 bits;
- res_id <= g;
- res_valid <= 1;
- rr_ptr <= (g+1) mod 4.
REQ-021 Latency SHALL be 1 cycle: a transfer in cycle N produces res_valid=1 with the result in cycle N+1.
REQ-022 With res_ready held at 1, throughput SHALL be one result per cycle.
REQ-023 On an edge with res_valid=1, res_ready=1 and no transfer, res_valid SHALL go to 0; res_sum, res_carry and res_id SHALL hold their values.
REQ-024 Output register state SHALL be EMPTY (res_valid=0) or FULL (res_valid=1), with these transitions:
- EMPTY->FULL on a transfer;
- FULL->FULL on a transfer with res_ready=1 (simultaneous drain and fill), or on res_ready=0;
- FULL->EMPTY on res_ready=1 with no transfer.
REQ-025 While res_valid=1 and res_ready=0, res_sum, res_carry and res_id SHALL be stable.
REQ-026 rr_ptr SHALL be unchanged in any cycle without a transfer.
REQ-027 Ungranted operands SHALL NOT be latched; each requester holds req_a/req_b stable while its req_valid=1 and it is not granted.
REQ-028 Sum overflow SHALL wrap modulo 2^W, with the overflow reported on res_carry.

Reset
REQ-029 While Rst=1, the block SHALL force res_valid=0, res_sum=0, res_carry=0, res_id=0, rr_ptr=0 and req_ready=0, immediately and independent of Clk.
REQ-030 A result held when Rst asserts SHALL be discarded and SHALL NOT be re-presented after reset.
REQ-031 The first grant after Rst deasserts SHALL be evaluated from rr_ptr=0.

Verification
REQ-032 The bench SHALL cover the following directed scenarios with DATAWIDTH=7:
- Wrap with carry: req_valid=0001, a0=8'hFF, b0=8'h01, res_ready=1 -> req_ready=0001 the same cycle; the next cycle shows res_valid=1, res_sum=8'h00, res_carry=1, res_id=0.
- Round-robin rotation: req_valid=1111 held, res_ready=1 -> req_ready sequence 0001,0010,0100,1000,0001 on consecutive cycles; res_id follows 0,1,2,3,0 one cycle later.
- Backpressure: result FULL, res_ready=0, req_valid=0100 for 5 cycles -> req_ready=0000 and res_* stable. Raising res_ready -> req_ready=0100 that cycle and the new result the next cycle, with no result lost.
- Pointer resume: after a grant to requester 3, req_valid=0101 -> grant 0001, then 0100.
- Reset mid-operation: Rst pulsed between edges while res_valid=1 -> res_valid=0 immediately. After release, req_valid=1010 -> grant 0010 (rr_ptr=0).
- Idle drain: FULL with res_ready=1 and req_valid=0000 -> res_valid=0 next cycle; res_sum unchanged.

Source files
------------

// File: rtl/add_arb.sv
// rtl/add_arb.sv - four-requester round-robin arbiter sharing one adder with a one-entry result register
// Ports:
//   Clk, Rst         rising-edge clock, asynchronous active-high reset
//   req_valid[3:0]   per-requester request valid
//   req_a, req_b     packed operands, requester i at [i*W +: W]
//   req_ready[3:0]   one-hot combinational grant
//   res_valid        result register holds an unconsumed result
//   res_sum, res_carry, res_id   held result, its carry-out and producing requester
//   res_ready        consumer accepts the held result this cycle
module add_arb #(
  parameter int DATAWIDTH = 63
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [3:0]                     req_valid,
  input  logic [4*(DATAWIDTH+1)-1:0]     req_a,
  input  logic [4*(DATAWIDTH+1)-1:0]     req_b,
  output logic [3:0]                     req_ready,
  output logic                           res_valid,
  output logic [DATAWIDTH:0]             res_sum,
  output logic                           res_carry,
  output logic [1:0]                     res_id,
  input  logic                           res_ready
);
  localparam int W = DATAWIDTH + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_next;
  logic [1:0]  rr_ptr;
  logic [1:0]  gidx;
  logic        found;
  logic [1:0]  idx;
  logic        can_accept;
  logic        xfer;
  logic [W-1:0] op_a, op_b;
  logic [W:0]   sum_full;

  assign res_valid  = (state == FULL);
  assign can_accept = !res_valid || res_ready;

  // Scan upward from rr_ptr and pick the first requesting index.
  always_comb begin
    gidx  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        gidx  = idx;
        found = 1'b1;
      end
    end
  end

  // Grant is suppressed during reset so no requester sees an accept it cannot complete.
  always_comb begin
    req_ready = 4'b0000;
    if (found && can_accept && !Rst) begin
      req_ready[gidx] = 1'b1;
    end
  end

  assign xfer = |req_ready;

  // The single shared adder, fed by the granted requester's operands.
  assign op_a     = req_a[gidx*W +: W];
  assign op_b     = req_b[gidx*W +: W];
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (xfer) state_next = FULL;
      FULL:  if (res_ready && !xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Result fields only load on a transfer; draining leaves them untouched.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= 2'd0;
      rr_ptr    <= 2'd0;
    end else if (xfer) begin
      {res_carry, res_sum} <= sum_full;
      res_id               <= gidx;
      rr_ptr               <= gidx + 2'd1;
    end
  end
endmodule

// File: tb/tb_add_arb.sv
// tb/tb_add_arb.sv - self-checking bench for add_arb with a behavioural reference model
module tb_add_arb;
  localparam int DW = 7;
  localparam int W  = DW + 1;

  logic           Clk;
  logic           Rst;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_ready;
  logic           res_valid;
  logic [W-1:0]   res_sum;
  logic           res_carry;
  logic [1:0]     res_id;
  logic           res_ready;

  add_arb #(.DATAWIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_sum(res_sum),
    .res_carry(res_carry), .res_id(res_id), .res_ready(res_ready)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit   m_valid;
  int   m_sum;
  int   m_carry;
  int   m_id;
  int   m_ptr;
  logic [3:0] last_ready;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_ptr = 0;
  endtask

  function automatic logic [3:0] model_grant();
    int i;
    if (Rst) return 4'b0000;
    if (m_valid && !res_ready) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      i = (m_ptr + k) % 4;
      if (req_valid[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  task automatic model_edge(input logic [3:0] g);
    int total;
    if (g != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          total   = int'(req_a[i*W +: W]) + int'(req_b[i*W +: W]);
          m_sum   = total % 256;
          m_carry = (total >= 256) ? 1 : 0;
          m_id    = i;
          m_valid = 1;
          m_ptr   = (i + 1) % 4;
        end
      end
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check("res_valid", res_valid, m_valid);
    check("res_sum", res_sum, m_sum);
    check("res_carry", res_carry, m_carry);
    check("res_id", res_id, m_id);
  endtask

  // Called at posedge+1; checks the grant before the edge and the result after it.
  task automatic cycle();
    logic [3:0] g;
    #3;
    g = model_grant();
    last_ready = req_ready;
    check("req_ready", req_ready, g);
    @(posedge Clk);
    model_edge(g);
    #1;
    check_outputs();
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  int saved_sum;
  int saved_id;
  int saved_carry;
  logic [3:0] rr_exp [5];

  initial begin
    Rst = 1'b1; req_valid = 4'b0000; req_a = '0; req_b = '0; res_ready = 1'b0;
    last_ready = 4'b0000;
    model_reset();
    #2;
    check("reset_res_valid", res_valid, 0);
    check("reset_res_sum", res_sum, 0);
    check("reset_req_ready", req_ready, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Round-robin rotation from rr_ptr=0
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_grant", last_ready, rr_exp[i]);
      check("rr_id", res_id, i % 4);
    end

    // Wrap with carry
    req_valid = 4'b0001; set_op(0, 8'hFF, 8'h01); res_ready = 1'b1;
    cycle();
    check("wrap_grant", last_ready, 4'b0001);
    check("wrap_sum", res_sum, 0);
    check("wrap_carry", res_carry, 1);
    check("wrap_id", res_id, 0);

    // Idle drain
    req_valid = 4'b0000; res_ready = 1'b1;
    cycle();
    check("drain_valid", res_valid, 0);
    check("drain_sum_hold", res_sum, 0);

    // Backpressure
    req_valid = 4'b0010; set_op(1, 8'h12, 8'h34); res_ready = 1'b0;
    cycle();
    saved_sum = res_sum; saved_id = res_id; saved_carry = res_carry;
    req_valid = 4'b0100; set_op(2, 8'hC0, 8'h50);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_ready", last_ready, 0);
      check("bp_sum_stable", res_sum, saved_sum);
      check("bp_id_stable", res_id, saved_id);
      check("bp_carry_stable", res_carry, saved_carry);
    end
    res_ready = 1'b1;
    cycle();
    check("bp_release_grant", last_ready, 4'b0100);
    check("bp_new_sum", res_sum, 8'h10);
    check("bp_new_carry", res_carry, 1);
    check("bp_new_id", res_id, 2);

    // Pointer resume after requester 3
    req_valid = 4'b1000; set_op(3, 3, 4);
    cycle();
    check("ptr_g3", last_ready, 4'b1000);
    req_valid = 4'b0101; set_op(0, 10, 20); set_op(2, 30, 40);
    cycle();
    check("ptr_g0", last_ready, 4'b0001);
    cycle();
    check("ptr_g2", last_ready, 4'b0100);

    // Reset mid-operation while FULL
    check("pre_reset_full", res_valid, 1);
    Rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid_now", res_valid, 0);
    check("rst_sum_now", res_sum, 0);
    check("rst_ready_now", req_ready, 0);
    #1;
    Rst = 1'b0;
    req_valid = 4'b1010; set_op(1, 1, 2); set_op(3, 5, 6);
    cycle();
    check("post_rst_grant", last_ready, 4'b0010);

    // Randomized traffic; ungranted requesters hold valid and operands
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
